// File: rtl/btn_pkg.sv
// Shared types and default timing for the button event decoder.
// Contents:
//   btn_state_e    gesture FSM states
//   DEF_*          default counter width and interval lengths (50 MHz clock)
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HELD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } btn_state_e;

  localparam int DEF_CNT_W      = 25;
  localparam int DEF_LONG_CYC   = 25000000;  // 0.5 s
  localparam int DEF_GAP_CYC    = 12500000;  // 0.25 s
  localparam int DEF_REPEAT_CYC = 5000000;   // 0.1 s

endpackage

// File: rtl/btn_edge_det.sv
// Edge detector for the debounced button level.
// Ports:
//   clk_i    system clock (rising edge)
//   rst_n_i  asynchronous active-low reset
//   level_i  debounced button level, 1 = pressed
//   rise_o   combinational: level went 0 -> 1 this cycle
//   fall_o   combinational: level went 1 -> 0 this cycle
// The level register comes out of reset at 0. The first cycle after reset
// only loads the real level and reports no edges, so a button held through
// reset release is not mistaken for a new press.
module btn_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic lvl_q;
  logic armed_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      lvl_q   <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q &  level_i & ~lvl_q;
  assign fall_o = armed_q & ~level_i &  lvl_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Button gesture classifier: turns a debounced button level into one-cycle
// event pulses for short press, double press and long press.
// Optional feature: define BTN_REPEAT_EN to emit auto-repeat ticks while a
// long press is held; without it REPEAT_PULSE is constant 0.
// Ports:
//   CLK           system clock (rising edge)
//   RST_N         asynchronous active-low reset
//   BTN_LEVEL     debounced button level, 1 = pressed, synchronous to CLK
//   SHORT_PULSE   one cycle: single short press completed
//   DOUBLE_PULSE  one cycle: double press completed
//   LONG_PULSE    one cycle: long-press threshold reached while held
//   REPEAT_PULSE  one cycle: auto-repeat tick while held
//   BUSY          FSM is not in IDLE
// LONG_CYC, GAP_CYC and REPEAT_CYC must each be below 2**CNT_W.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LONG_CYC   = DEF_LONG_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_LEVEL,
  output logic SHORT_PULSE,
  output logic DOUBLE_PULSE,
  output logic LONG_PULSE,
  output logic REPEAT_PULSE,
  output logic BUSY
);

  // Thresholds are compared against the counter value one cycle before the
  // interval ends, so the registered pulse lands exactly on the interval.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  logic rise;
  logic fall;

  btn_edge_det u_edge (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .level_i (BTN_LEVEL),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             tick_clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      rep_q    <= rep_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    tick_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        // A release on the threshold cycle still counts as a short press.
        if (fall) begin
          state_d = GAP;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt_q == REP_LAST) begin
          // Repeat ticks restart the interval without leaving HELD.
          rep_d    = 1'b1;
          tick_clr = 1'b1;
        end
`endif
      end
      GAP: begin
        // A re-press on the timeout cycle still makes a double press.
        if (rise) begin
          state_d = PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Interval counter: restarts on every state change, saturates otherwise.
    if ((state_d != state_q) || tick_clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign SHORT_PULSE  = short_q;
  assign DOUBLE_PULSE = double_q;
  assign LONG_PULSE   = long_q;
  assign BUSY         = (state_q != IDLE);
`ifdef BTN_REPEAT_EN
  assign REPEAT_PULSE = rep_q;
`else
  assign REPEAT_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG_CYC=20, GAP_CYC=10,
// REPEAT_CYC=5. Inputs change on the falling edge; outputs are sampled on
// the falling edge, after the rising edge numbered by cyc.
module tb_btn_event_decoder;

  logic CLK;
  logic RST_N;
  logic BTN_LEVEL;
  logic SHORT_PULSE;
  logic DOUBLE_PULSE;
  logic LONG_PULSE;
  logic REPEAT_PULSE;
  logic BUSY;

  btn_event_decoder #(
    .CNT_W      (25),
    .LONG_CYC   (20),
    .GAP_CYC    (10),
    .REPEAT_CYC (5)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .BTN_LEVEL    (BTN_LEVEL),
    .SHORT_PULSE  (SHORT_PULSE),
    .DOUBLE_PULSE (DOUBLE_PULSE),
    .LONG_PULSE   (LONG_PULSE),
    .REPEAT_PULSE (REPEAT_PULSE),
    .BUSY         (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_multi = 0;
  int n_s, n_d, n_l, n_r;
  int t_s, t_d, t_l, t_r0, t_r;
  int r, f;

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_s = 0; n_d = 0; n_l = 0; n_r = 0;
    t_s = -1; t_d = -1; t_l = -1; t_r0 = -1; t_r = -1;
  endtask

  task automatic sample();
    int np;
    np = int'(SHORT_PULSE) + int'(DOUBLE_PULSE) + int'(LONG_PULSE) + int'(REPEAT_PULSE);
    if (np > 1) n_multi++;
    if (SHORT_PULSE)  begin n_s++; t_s = cyc; end
    if (DOUBLE_PULSE) begin n_d++; t_d = cyc; end
    if (LONG_PULSE)   begin n_l++; t_l = cyc; end
    if (REPEAT_PULSE) begin
      if (n_r == 0) t_r0 = cyc;
      n_r++;
      t_r = cyc;
    end
  endtask

  // Apply level v for n rising edges, monitoring outputs after each edge.
  task automatic hold(input logic v, input int n);
    BTN_LEVEL = v;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cyc++;
      sample();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_short"},  int'(SHORT_PULSE),  0);
    check_val({tag, "_double"}, int'(DOUBLE_PULSE), 0);
    check_val({tag, "_long"},   int'(LONG_PULSE),   0);
    check_val({tag, "_repeat"}, int'(REPEAT_PULSE), 0);
    check_val({tag, "_busy"},   int'(BUSY),         0);
  endtask

  initial begin
    RST_N = 1'b0;
    BTN_LEVEL = 1'b0;
    clear_mon();
    @(negedge CLK);
    hold(1'b0, 3);
    check_outputs_zero("rst");
    RST_N = 1'b1;
    hold(1'b0, 3);
    check_val("idle_busy", int'(BUSY), 0);

    // Single short press: SHORT 10 cycles after the fall edge.
    clear_mon();
    hold(1'b1, 5);
    check_val("short_busy_held", int'(BUSY), 1);
    f = cyc + 1;
    hold(1'b0, 15);
    check_val("short_n", n_s, 1);
    check_val("short_t", t_s, f + 10);
    check_val("short_no_dbl", n_d, 0);
    check_val("short_no_long", n_l, 0);
    check_val("short_no_rep", n_r, 0);
    check_val("short_busy_end", int'(BUSY), 0);

    // Double press: DOUBLE right after the second fall edge.
    clear_mon();
    hold(1'b1, 5);
    hold(1'b0, 4);
    hold(1'b1, 5);
    f = cyc + 1;
    hold(1'b0, 15);
    check_val("dbl_n", n_d, 1);
    check_val("dbl_t", t_d, f);
    check_val("dbl_no_short", n_s, 0);
    check_val("dbl_no_long", n_l, 0);
    check_val("dbl_busy_end", int'(BUSY), 0);

    // Long hold: LONG 20 cycles after the rise, repeats only when enabled.
    clear_mon();
    r = cyc + 1;
    hold(1'b1, 40);
    hold(1'b0, 20);
    check_val("long_n", n_l, 1);
    check_val("long_t", t_l, r + 20);
    check_val("long_no_short", n_s, 0);
    check_val("long_no_dbl", n_d, 0);
`ifdef BTN_REPEAT_EN
    check_val("rep_n", n_r, 3);
    check_val("rep_first_t", t_r0, r + 25);
    check_val("rep_last_t", t_r, r + 35);
`else
    check_val("rep_n", n_r, 0);
`endif
    check_val("long_busy_end", int'(BUSY), 0);

    // Release on the last cycle before the long threshold: short, not long.
    clear_mon();
    r = cyc + 1;
    hold(1'b1, 20);
    f = cyc + 1;
    hold(1'b0, 15);
    check_val("edge_long_n", n_l, 0);
    check_val("edge_short_n", n_s, 1);
    check_val("edge_short_t", t_s, f + 10);

    // Re-press on the last gap cycle: double, not short.
    clear_mon();
    hold(1'b1, 5);
    hold(1'b0, 10);
    hold(1'b1, 5);
    f = cyc + 1;
    hold(1'b0, 15);
    check_val("edge_gap_short_n", n_s, 0);
    check_val("edge_gap_dbl_n", n_d, 1);
    check_val("edge_gap_dbl_t", t_d, f);

    // Gap timeout one cycle earlier than the re-press: short, then new gesture.
    clear_mon();
    hold(1'b1, 5);
    f = cyc + 1;
    hold(1'b0, 11);
    check_val("late_short_t", t_s, f + 10);
    hold(1'b1, 5);
    hold(1'b0, 15);
    check_val("late_short_n", n_s, 2);
    check_val("late_dbl_n", n_d, 0);

    // Reset during GAP: everything clears at once, gesture discarded.
    clear_mon();
    hold(1'b1, 5);
    hold(1'b0, 3);
    check_val("gap_busy", int'(BUSY), 1);
    RST_N = 1'b0;
    #1;
    check_outputs_zero("rst_gap");
    hold(1'b0, 3);
    RST_N = 1'b1;
    hold(1'b0, 20);
    check_val("rst_gap_short_n", n_s, 0);
    check_val("rst_gap_dbl_n", n_d, 0);
    check_val("rst_gap_busy_end", int'(BUSY), 0);

    // Button held through reset release: not a press, no events.
    clear_mon();
    RST_N = 1'b0;
    BTN_LEVEL = 1'b1;
    hold(1'b1, 3);
    RST_N = 1'b1;
    hold(1'b1, 30);
    check_val("held_rst_busy", int'(BUSY), 0);
    hold(1'b0, 20);
    check_val("held_rst_short", n_s, 0);
    check_val("held_rst_dbl", n_d, 0);
    check_val("held_rst_long", n_l, 0);
    check_val("held_rst_rep", n_r, 0);

    // A normal press right after still works.
    clear_mon();
    hold(1'b1, 5);
    f = cyc + 1;
    hold(1'b0, 15);
    check_val("post_rst_short_t", t_s, f + 10);

    check_val("one_hot_pulses", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
